// File: rtl/riscv_mc_ctrl.sv
// riscv_mc_ctrl: multicycle control FSM for a RISC-V datapath with a shared
// instruction/data memory. Sequences one instruction over 3-5 states, drives
// the datapath mux selects, write strobes and ALU operation, waits on a memory
// ready handshake, traps (sticky) on illegal instructions and counts retired
// instructions.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   op, funct3,     instruction register fields instr[6:0], instr[14:12],
//   funct7b5        instr[30]
//   zero            ALU zero flag (branch decision)
//   mem_ready       memory completes the current access this cycle
//   mem_req, mem_write, adr_src         memory interface controls
//   ir_write, pc_write, reg_write       architectural write strobes
//   result_src, alu_src_a, alu_src_b    datapath mux selects
//   imm_src, alu_ctrl                   immediate format, ALU operation
//   state, illegal, retired             status: FSM state, trap flag, count
module riscv_mc_ctrl #(
    parameter int unsigned RETIRE_W        = 32,
    parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          op,
    input  logic [2:0]          funct3,
    input  logic                funct7b5,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_write,
    output logic                adr_src,
    output logic                ir_write,
    output logic                pc_write,
    output logic                reg_write,
    output logic [1:0]          result_src,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          imm_src,
    output logic [2:0]          alu_ctrl,
    output logic [3:0]          state,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam state_e S_ILLEGAL_NEXT = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
    localparam logic [RETIRE_W-1:0] RETIRE_ONE = {{(RETIRE_W-1){1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;
    logic                alu_f3_ok;
    logic [2:0]          alu_dec;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // ALU operation from funct3; legality is checked in DECODE so EXECR/EXECI
    // only ever see one of the four supported encodings.
    always_comb begin
        alu_f3_ok = 1'b1;
        alu_dec   = ALU_ADD;
        case (funct3)
            3'b000:  alu_dec = (op == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_dec = ALU_SLT;
            3'b110:  alu_dec = ALU_OR;
            3'b111:  alu_dec = ALU_AND;
            default: alu_f3_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = alu_f3_ok ? S_EXECR : S_ILLEGAL_NEXT;
                    OP_I:         state_d = alu_f3_ok ? S_EXECI : S_ILLEGAL_NEXT;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = (funct3 == 3'b000) ? S_BEQ : S_ILLEGAL_NEXT;
                    default:      state_d = S_ILLEGAL_NEXT;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_BEQ:      state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
    end

    // Retire in the last cycle of each instruction; JAL retires through ALUWB.
    always_comb begin
        retired_d = retired_q;
        if (state_q == S_MEMWB || state_q == S_ALUWB || state_q == S_BEQ ||
            (state_q == S_MEMWRITE && mem_ready))
            retired_d = retired_q + RETIRE_ONE;
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_ctrl   = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_ctrl  = alu_dec;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_ctrl  = alu_dec;
            end
            S_ALUWB: reg_write = 1'b1;
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_ctrl  = ALU_SUB;
                pc_write  = zero;
            end
            default: ;
        endcase
        // The state register already reads FETCH during reset; the strobes are
        // gated here so FETCH's request/loads cannot fire while rst is low.
        if (!rst) begin
            mem_req   = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
        end
    end

    always_comb begin
        case (op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    assign state   = state_q;
    assign illegal = (state_q == S_TRAP);
    assign retired = retired_q;

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
module tb_riscv_mc_ctrl;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_JAL = 4, K_BEQ = 5, K_ILL = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic funct7b5 = 1'b0;
    logic zero = 1'b0;
    logic mem_ready = 1'b0;

    logic a_mem_req, a_mem_write, a_adr_src, a_ir_write, a_pc_write, a_reg_write, a_illegal;
    logic [1:0] a_result_src, a_alu_src_a, a_alu_src_b, a_imm_src;
    logic [2:0] a_alu_ctrl;
    logic [3:0] a_state;
    logic [31:0] a_retired;

    logic b_mem_req, b_mem_write, b_adr_src, b_ir_write, b_pc_write, b_reg_write, b_illegal;
    logic [1:0] b_result_src, b_alu_src_a, b_alu_src_b, b_imm_src;
    logic [2:0] b_alu_ctrl;
    logic [3:0] b_state;
    logic [3:0] b_retired;

    riscv_mc_ctrl #(.RETIRE_W(32), .TRAP_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready),
        .mem_req(a_mem_req), .mem_write(a_mem_write), .adr_src(a_adr_src),
        .ir_write(a_ir_write), .pc_write(a_pc_write), .reg_write(a_reg_write),
        .result_src(a_result_src), .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b),
        .imm_src(a_imm_src), .alu_ctrl(a_alu_ctrl), .state(a_state),
        .illegal(a_illegal), .retired(a_retired)
    );

    // Second instance: skips illegal instructions and has a narrow counter so
    // the wrap from all-ones to zero is reached.
    riscv_mc_ctrl #(.RETIRE_W(4), .TRAP_ON_ILLEGAL(1'b0)) dut_nt (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready),
        .mem_req(b_mem_req), .mem_write(b_mem_write), .adr_src(b_adr_src),
        .ir_write(b_ir_write), .pc_write(b_pc_write), .reg_write(b_reg_write),
        .result_src(b_result_src), .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b),
        .imm_src(b_imm_src), .alu_ctrl(b_alu_ctrl), .state(b_state),
        .illegal(b_illegal), .retired(b_retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  state;
        logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
        logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
        logic [2:0]  alu_ctrl;
        logic        illegal;
        logic [31:0] retired;
    } obs_t;

    typedef struct packed {
        obs_t       a;
        logic [3:0] b_state;
        logic [3:0] b_retired;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int failures = 0;
    logic [31:0] cnt = '0;

    // Operation the ALU must perform for an R/I-type instruction.
    function automatic logic [2:0] alu_of(logic [6:0] o, logic [2:0] f3, logic f7);
        case (f3)
            3'b000:  return (o == OP_R && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Control outputs the datapath needs in each named step of an instruction.
    function automatic obs_t ctl(logic [3:0] s, logic [6:0] o, logic [2:0] f3, logic f7,
                                 logic z, logic rdy, logic [31:0] ret);
        obs_t r = '0;
        r.state   = s;
        r.retired = ret;
        r.imm_src = (o == OP_SW) ? 2'b01 : (o == OP_BEQ) ? 2'b10 : (o == OP_JAL) ? 2'b11 : 2'b00;
        case (s)
            4'd0:  begin r.mem_req = 1; r.alu_src_b = 2; r.result_src = 2;
                         r.ir_write = rdy; r.pc_write = rdy; end
            4'd1:  begin r.alu_src_a = 1; r.alu_src_b = 1; end
            4'd2:  begin r.alu_src_a = 2; r.alu_src_b = 1; end
            4'd3:  begin r.mem_req = 1; r.adr_src = 1; end
            4'd4:  begin r.result_src = 1; r.reg_write = 1; end
            4'd5:  begin r.mem_req = 1; r.mem_write = 1; r.adr_src = 1; end
            4'd6:  begin r.alu_src_a = 2; r.alu_ctrl = alu_of(o, f3, f7); end
            4'd7:  r.reg_write = 1;
            4'd8:  begin r.alu_src_a = 2; r.alu_src_b = 1; r.alu_ctrl = alu_of(o, f3, f7); end
            4'd9:  begin r.alu_src_a = 1; r.alu_src_b = 2; r.pc_write = 1; end
            4'd10: begin r.alu_src_a = 2; r.alu_ctrl = 3'b001; r.pc_write = z; end
            4'd11: r.illegal = 1;
            default: ;
        endcase
        return r;
    endfunction

    // Monitor: compares every cycle for which an expectation was queued.
    exp_t mon_e;
    obs_t mon_got;
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            mon_got = {a_state, a_mem_req, a_mem_write, a_adr_src, a_ir_write, a_pc_write,
                       a_reg_write, a_result_src, a_alu_src_a, a_alu_src_b, a_imm_src,
                       a_alu_ctrl, a_illegal, a_retired};
            checks++;
            if (mon_got !== mon_e.a) begin
                failures++;
                $display("FAIL ctrl state=%0d: got=%h exp=%h", mon_e.a.state, mon_got, mon_e.a);
            end
            checks++;
            if ({b_state, b_retired} !== {mon_e.b_state, mon_e.b_retired}) begin
                failures++;
                $display("FAIL noTrap state/retired: got=%0d/%0d exp=%0d/%0d",
                         b_state, b_retired, mon_e.b_state, mon_e.b_retired);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h exp=%h", name, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, queue expectation, advance.
    task automatic step(input logic [3:0] s, input logic rdy, input logic z,
                        input bit fin, input logic [3:0] s2);
        exp_t e;
        mem_ready = rdy;
        zero      = z;
        e.a         = ctl(s, op, funct3, funct7b5, z, rdy, cnt);
        e.b_state   = s2;
        e.b_retired = cnt[3:0];
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (fin) cnt = cnt + 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("rst_state", {28'd0, a_state}, 32'd0);
        chk("rst_strobes", {27'd0, a_mem_req, a_mem_write, a_ir_write, a_pc_write, a_reg_write}, 32'd0);
        chk("rst_illegal", {31'd0, a_illegal}, 32'd0);
        chk("rst_retired", a_retired, 32'd0);
        chk("rst_nt", {24'd0, b_state, b_retired}, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        cnt = '0;
    endtask

    task automatic run_instr(input int kind, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic z, input int fs, input int ms);
        logic r;
        op = o; funct3 = f3; funct7b5 = f7;
        for (int i = 0; i < fs; i++) step(4'd0, 1'b0, z, 0, 4'd0);
        step(4'd0, 1'b1, z, 0, 4'd0);
        r = 1'($urandom_range(0, 1));
        step(4'd1, r, z, 0, 4'd1);
        case (kind)
            K_R:   begin step(4'd6, r, z, 0, 4'd6); step(4'd7, r, z, 1, 4'd7); end
            K_I:   begin step(4'd8, r, z, 0, 4'd8); step(4'd7, r, z, 1, 4'd7); end
            K_JAL: begin step(4'd9, r, z, 0, 4'd9); step(4'd7, r, z, 1, 4'd7); end
            K_BEQ: step(4'd10, r, z, 1, 4'd10);
            K_LW: begin
                step(4'd2, r, z, 0, 4'd2);
                for (int i = 0; i < ms; i++) step(4'd3, 1'b0, z, 0, 4'd3);
                step(4'd3, 1'b1, z, 0, 4'd3);
                step(4'd4, r, z, 1, 4'd4);
            end
            K_SW: begin
                step(4'd2, r, z, 0, 4'd2);
                for (int i = 0; i < ms; i++) step(4'd5, 1'b0, z, 0, 4'd5);
                step(4'd5, 1'b1, z, 1, 4'd5);
            end
            default: begin
                // Trapping instance stays in TRAP; the skipping one returns to
                // FETCH and idles there because memory never becomes ready.
                for (int i = 0; i < 20; i++) step(4'd11, 1'b0, z, 0, 4'd0);
                do_reset();
            end
        endcase
    endtask

    logic [2:0] legal_f3 [4] = '{3'b000, 3'b010, 3'b110, 3'b111};
    logic [2:0] bad_f3   [4] = '{3'b001, 3'b011, 3'b100, 3'b101};
    logic [6:0] bad_op   [4] = '{7'b0000000, 7'b1110011, 7'b0110111, 7'b0010111};

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state0", {28'd0, a_state}, 32'd0);
        chk("rst_strobes0", {27'd0, a_mem_req, a_mem_write, a_ir_write, a_pc_write, a_reg_write}, 32'd0);
        chk("rst_illegal0", {31'd0, a_illegal}, 32'd0);
        chk("rst_retired0", a_retired, 32'd0);
        #1;
        rst = 1'b1;

        run_instr(K_R, OP_R, 3'b000, 1'b1, 1'b0, 0, 0);
        run_instr(K_LW, OP_LW, 3'b010, 1'b0, 1'b0, 3, 3);
        run_instr(K_BEQ, OP_BEQ, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr(K_BEQ, OP_BEQ, 3'b000, 1'b0, 1'b1, 0, 0);
        run_instr(K_JAL, OP_JAL, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr(K_ILL, 7'b0000000, 3'b000, 1'b0, 1'b0, 0, 0);

        // Store abandoned by reset while waiting on memory.
        op = OP_SW; funct3 = 3'b010; funct7b5 = 1'b0;
        step(4'd0, 1'b1, 1'b0, 0, 4'd0);
        step(4'd1, 1'b0, 1'b0, 0, 4'd1);
        step(4'd2, 1'b0, 1'b0, 0, 4'd2);
        step(4'd5, 1'b0, 1'b0, 0, 4'd5);
        #2;
        chk("sw_pending_write", {31'd0, a_mem_write}, 32'd1);
        do_reset();
        chk("sw_abort_retired", a_retired, 32'd0);

        for (int n = 0; n < 120; n++) begin
            k = $urandom_range(0, 9);
            case (k)
                0, 1: run_instr(K_R, OP_R, legal_f3[$urandom_range(0, 3)], 1'($urandom),
                                1'($urandom), $urandom_range(0, 3), 0);
                2:    run_instr(K_I, OP_I, legal_f3[$urandom_range(0, 3)], 1'($urandom),
                                1'($urandom), $urandom_range(0, 3), 0);
                3, 4: run_instr(K_LW, OP_LW, 3'($urandom), 1'($urandom), 1'($urandom),
                                $urandom_range(0, 3), $urandom_range(0, 3));
                5:    run_instr(K_SW, OP_SW, 3'($urandom), 1'($urandom), 1'($urandom),
                                $urandom_range(0, 3), $urandom_range(0, 3));
                6:    run_instr(K_JAL, OP_JAL, 3'($urandom), 1'($urandom), 1'($urandom),
                                $urandom_range(0, 3), 0);
                7, 9: run_instr(K_BEQ, OP_BEQ, 3'b000, 1'($urandom), 1'($urandom),
                                $urandom_range(0, 3), 0);
                default: begin
                    case ($urandom_range(0, 2))
                        0: run_instr(K_ILL, bad_op[$urandom_range(0, 3)], 3'($urandom),
                                     1'($urandom), 1'($urandom), 0, 0);
                        1: run_instr(K_ILL, ($urandom_range(0, 1) != 0) ? OP_R : OP_I,
                                     bad_f3[$urandom_range(0, 3)], 1'($urandom), 1'($urandom), 0, 0);
                        default: run_instr(K_ILL, OP_BEQ, 3'($urandom_range(1, 7)),
                                           1'($urandom), 1'($urandom), 0, 0);
                    endcase
                end
            endcase
        end

        @(negedge clk);
        chk("queue_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/riscv_mc_ctrl.md
Name: riscv_mc_ctrl

Overview:
- Multicycle control FSM for the RISC-V datapath (register file, ALU, shared instruction/data memory).
- Decodes the instruction register fields and sequences one instruction over 3–5 states.
- Drives the datapath mux selects, write strobes and ALU operation.
- Adds a memory ready handshake, a sticky illegal-instruction trap and a retired-instruction counter.

Parameters:
- RETIRE_W, 32: width of the retired-instruction counter.
- TRAP_ON_ILLEGAL, 1: 1 means an illegal instruction enters TRAP; 0 means it is skipped like a nop and the FSM returns to FETCH.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- op  in  7  instr[6:0].
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_write  out  1  memory write enable.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  instruction register load.
- pc_write  out  1  PC load.
- reg_write  out  1  register file write.
- result_src  out  2  00 ALUOut, 01 read data, 10 ALU result.
- alu_src_a  out  2  00 PC, 01 old PC, 10 rs1.
- alu_src_b  out  2  00 rs2, 01 imm, 10 constant 4.
- imm_src  out  2  00 I, 01 S, 10 B, 11 J.
- alu_ctrl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- state  out  4  current state encoding.
- illegal  out  1  high while in TRAP.
- retired  out  RETIRE_W  count of completed instructions.

Behaviour:
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, ALUWB 7, EXECI 8, JAL 9, BEQ 10, TRAP 11.
- Reset (rst low, asynchronous):
  - state = FETCH, retired = 0, illegal = 0.
  - pc_write, ir_write, reg_write, mem_write and mem_req are forced to 0 while rst is low.
  - Reset asserted mid-instruction abandons that instruction; no strobe fires.
- Unlisted outputs default to 0 in every state; alu_ctrl defaults to add.
- imm_src is decoded combinationally from op in all states: sw → S, beq → B, jal → J, otherwise I.
- FETCH:
  - mem_req = 1, adr_src = 0, alu_src_a = 00, alu_src_b = 10, add, result_src = 10.
  - ir_write and pc_write are high only when mem_ready = 1.
  - Stays in FETCH while mem_ready = 0; goes to DECODE when mem_ready = 1.
- DECODE: alu_src_a = 01, alu_src_b = 01, add (branch target into ALUOut). Next state:
  - lw 0000011 or sw 0100011 → MEMADR.
  - R-type 0110011 → EXECR.
  - I-type 0010011 → EXECI.
  - jal 1101111 → JAL.
  - beq 1100011 with funct3 = 000 → BEQ.
  - Anything else is illegal.
- MEMADR: alu_src_a = 10, alu_src_b = 01, add. Next is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: mem_req = 1, adr_src = 1, result_src = 00. Holds until mem_ready, then MEMWB.
- MEMWB: result_src = 01, reg_write = 1. Next FETCH.
- MEMWRITE: mem_req = 1, mem_write = 1, adr_src = 1. Holds until mem_ready, then FETCH.
- EXECR / EXECI: alu_src_a = 10; alu_src_b = 00 (EXECR) or 01 (EXECI). Next ALUWB.
- ALUWB: result_src = 00, reg_write = 1. Next FETCH.
- JAL: alu_src_a = 01, alu_src_b = 10, add, result_src = 00, pc_write = 1. Next ALUWB (writes PC+4 to rd).
- BEQ: alu_src_a = 10, alu_src_b = 00, sub, result_src = 00, pc_write = zero. Next FETCH.
- ALU decode (EXECR/EXECI), by funct3:
  - 000: sub only if R-type and funct7b5 = 1; otherwise add.
  - 010: slt.
  - 110: or.
  - 111: and.
  - Any other funct3 is illegal. An illegal funct3 is detected in DECODE, so EXECR/EXECI is never entered with it.
- Illegal instruction:
  - TRAP_ON_ILLEGAL = 1: DECODE → TRAP. TRAP is sticky until reset, illegal = 1, all strobes 0.
  - TRAP_ON_ILLEGAL = 0: DECODE → FETCH with no strobes and no retire.
- Retire: retired increments by 1 in the final cycle of an instruction. That is:
  - MEMWB;
  - the MEMWRITE cycle with mem_ready = 1;
  - ALUWB;
  - BEQ.
  - JAL retires only via its ALUWB, so it counts once.
  - The counter wraps from all-ones to 0.
- mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.

Test Plan:
- sub x4,x4,x5 (op 0110011, funct3 000, funct7b5 1), mem_ready always 1 → states 0,1,6,7,0; alu_ctrl = 001 in EXECR; reg_write = 1 only in ALUWB; retired = 1.
- lw with mem_ready held low 3 cycles in both FETCH and MEMREAD → FSM stalls exactly 3 extra cycles in each; ir_write/pc_write pulse once; reg_write in MEMWB; retired = 1.
- beq, funct3 000: run once with zero = 0 and once with zero = 1 → pc_write = 0 and 1 respectively in BEQ; imm_src = 10; alu_ctrl = 001; retired increments both times.
- jal (op 1101111) → states 0,1,9,7,0; pc_write high in FETCH and JAL; reg_write in ALUWB; retired +1 (not +2).
- op 0000000 → TRAP (state 11), illegal = 1, no strobes for 20 cycles; rst low → FETCH, illegal = 0, retired = 0. Repeat with TRAP_ON_ILLEGAL = 0 → returns to FETCH, retired unchanged.
- sw, assert rst low in MEMWRITE while mem_ready = 0 → mem_write drops immediately (asynchronous); state = FETCH; retired unchanged (0).
